// File: rtl/mux_2x1_arb.sv
// mux_2x1_arb
//   Round-robin arbiter that owns the 2:1 select line shared by two
//   requesters. One requester at a time is granted for a burst of up to
//   MAX_HOLD beats. The granted data is forwarded over a valid/ready
//   handshake to a single downstream consumer.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req1/x1/last1  requester 1 beat request, data, end-of-burst flag
//   req2/x2/last2  requester 2 beat request, data, end-of-burst flag
//   f_ready        downstream accepts the beat on f
//   f              muxed data, s ? x2 : x1
//   f_valid        granted requester has a beat
//   f_last         end-of-burst flag of the granted requester, gated by f_valid
//   rdy1/rdy2      per-requester ready (grant & f_ready)
//   gnt1/gnt2      registered one-hot grant
//   s              registered select; holds its value while idle
module mux_2x1_arb #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req1,
    input  logic [W-1:0] x1,
    input  logic         last1,
    input  logic         req2,
    input  logic [W-1:0] x2,
    input  logic         last2,
    input  logic         f_ready,
    output logic [W-1:0] f,
    output logic         f_valid,
    output logic         f_last,
    output logic         rdy1,
    output logic         rdy2,
    output logic         gnt1,
    output logic         gnt2,
    output logic         s
);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nx;
    logic       s_nx;
    logic       last_srv, last_srv_nx;   // 0: requester 1 served last, 1: requester 2
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic       acc, at_max, rel, enter1, enter2;

    assign gnt1    = (state == G1);
    assign gnt2    = (state == G2);
    assign f       = s ? x2 : x1;
    assign f_valid = (gnt1 & req1) | (gnt2 & req2);
    assign f_last  = (gnt1 & req1 & last1) | (gnt2 & req2 & last2);
    assign rdy1    = gnt1 & f_ready;
    assign rdy2    = gnt2 & f_ready;
    assign acc     = f_valid & f_ready;
    assign at_max  = (beat_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= 1'b0;
            last_srv <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            s        <= s_nx;
            last_srv <= last_srv_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        s_nx        = s;
        last_srv_nx = last_srv;
        beat_cnt_nx = beat_cnt;
        rel         = 1'b0;
        enter1      = 1'b0;
        enter2      = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (req1 && (!req2 || last_srv)) enter1 = 1'b1;
                else if (req2)                   enter2 = 1'b1;
            end
            G1: begin
                rel = !req1 || (acc && (last1 || at_max));
                if (rel) begin
                    if (req2)      enter2   = 1'b1;
                    else if (req1) enter1   = 1'b1;   // req1 high here implies no drop
                    else           state_nx = IDLE;
                end else if (acc) begin
                    beat_cnt_nx = beat_cnt + 8'd1;
                end
            end
            G2: begin
                rel = !req2 || (acc && (last2 || at_max));
                if (rel) begin
                    if (req1)      enter1   = 1'b1;
                    else if (req2) enter2   = 1'b1;
                    else           state_nx = IDLE;
                end else if (acc) begin
                    beat_cnt_nx = beat_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Grant entry (fresh or re-entry) restarts the burst count.
        if (enter1) begin
            state_nx    = G1;
            s_nx        = 1'b0;
            last_srv_nx = 1'b0;
            beat_cnt_nx = '0;
        end
        if (enter2) begin
            state_nx    = G2;
            s_nx        = 1'b1;
            last_srv_nx = 1'b1;
            beat_cnt_nx = '0;
        end
    end

endmodule

// File: tb/tb_mux_2x1_arb.sv
// Testbench for mux_2x1_arb: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_mux_2x1_arb;

    localparam int W  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst_n, req1, last1, req2, last2, f_ready;
    logic [W-1:0] x1, x2, f;
    logic         f_valid, f_last, rdy1, rdy2, gnt1, gnt2, s;

    int total = 0;
    int bad   = 0;

    // Behavioural model: owner 0 = nobody, 1/2 = requester number.
    int m_owner = 0;
    int m_last  = 2;
    int m_cnt   = 0;
    bit m_s     = 1'b0;

    always #5 clk = ~clk;

    mux_2x1_arb #(.W(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .x1(x1), .last1(last1),
        .req2(req2), .x2(x2), .last2(last2),
        .f_ready(f_ready), .f(f), .f_valid(f_valid), .f_last(f_last),
        .rdy1(rdy1), .rdy2(rdy2), .gnt1(gnt1), .gnt2(gnt2), .s(s)
    );

    function automatic logic [W+6:0] exp_vec();
        bit fv, fl;
        fv = (m_owner == 1 && req1) || (m_owner == 2 && req2);
        fl = fv && ((m_owner == 1) ? last1 : last2);
        return {m_owner == 1, m_owner == 2, m_s, fv, fl,
                m_owner == 1 && f_ready, m_owner == 2 && f_ready,
                m_s ? x2 : x1};
    endfunction

    // Advance the model by one clock using the inputs present before the edge,
    // then let the DUT clock and return at the following falling edge.
    task automatic step();
        int no, nl, nc, pick;
        bit ns, fv, acc, own, oth, olast, drop, relz;
        no = m_owner; nl = m_last; nc = m_cnt; ns = m_s; pick = 0;
        fv  = (m_owner == 1 && req1) || (m_owner == 2 && req2);
        acc = fv && f_ready;
        if (!rst_n) begin
            no = 0; nl = 2; nc = 0; ns = 1'b0;
        end else if (m_owner == 0) begin
            if (req1 && req2) pick = (m_last == 1) ? 2 : 1;
            else if (req1)    pick = 1;
            else if (req2)    pick = 2;
        end else begin
            own   = (m_owner == 1) ? req1  : req2;
            oth   = (m_owner == 1) ? req2  : req1;
            olast = (m_owner == 1) ? last1 : last2;
            drop  = !own;
            relz  = drop || (acc && (olast || m_cnt == MH - 1));
            if (relz) begin
                if (oth)               pick = 3 - m_owner;
                else if (own && !drop) pick = m_owner;
                else                   no   = 0;
            end else begin
                nc = m_cnt + (acc ? 1 : 0);
            end
        end
        if (rst_n && pick != 0) begin
            no = pick; nl = pick; nc = 0; ns = (pick == 2);
        end
        @(posedge clk);
        m_owner = no; m_last = nl; m_cnt = nc; m_s = ns;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; last1 = 1'b0; last2 = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req1 = 1'b1; req2 = 1'b1; last1 = 1'b0; last2 = 1'b0;
        f_ready = 1'b1; x1 = 8'h3C; x2 = 8'hC3;
        step();
        step();
        #1;
        total++; if (gnt1 !== 1'b0 || gnt2 !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b%b want 00", gnt1, gnt2); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL reset_s: got %b want 0", s); end
        total++; if (f_valid !== 1'b0 || f_last !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b%b want 00", f_valid, f_last); end
        total++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b%b want 00", rdy1, rdy2); end
        total++; if (f !== 8'h3C) begin bad++; $display("FAIL reset_f: got %h want 3c", f); end
        total++; if (dut.beat_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dut.beat_cnt); end
    endtask

    task automatic test_single_burst();
        int beats = 0;
        rst_n = 1'b1; req1 = 1'b1; req2 = 1'b0; x1 = 8'hA5; last1 = 1'b0; f_ready = 1'b1;
        #1;
        total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL burst_lat: got gnt1=%b want 0", gnt1); end
        step();
        for (int b = 0; b < 3; b++) begin
            last1 = (b == 2);
            #1;
            if (f_valid && f_ready) beats++;
            total++;
            if ({gnt1, f_valid, rdy1, f} !== {3'b111, 8'hA5}) begin
                bad++; $display("FAIL burst_beat%0d: got %b%b%b %h want 111 a5", b, gnt1, f_valid, rdy1, f);
            end
            step();
        end
        total++; if (beats !== 3) begin bad++; $display("FAIL burst_count: got %0d want 3", beats); end
        req1 = 1'b0; last1 = 1'b0;
        #1;
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL burst_drop_valid: got %b want 0", f_valid); end
        step();
        #1;
        total++; if (gnt1 !== 1'b0 || s !== 1'b0) begin bad++; $display("FAIL burst_idle: got gnt1=%b s=%b want 0 0", gnt1, s); end
    endtask

    task automatic test_alternate();
        bit e1;
        do_reset();
        req1 = 1'b1; req2 = 1'b1; last1 = 1'b0; last2 = 1'b0; f_ready = 1'b1;
        x1 = 8'h11; x2 = 8'h22;
        step();
        for (int k = 0; k < 12; k++) begin
            e1 = ((k / MH) % 2) == 0;
            #1;
            total++;
            if ({gnt1, gnt2, s, f_valid, f} !== {e1, !e1, !e1, 1'b1, (e1 ? 8'h11 : 8'h22)}) begin
                bad++; $display("FAIL alt_cycle%0d: got g=%b%b s=%b v=%b f=%h want g=%b%b s=%b v=1",
                                k, gnt1, gnt2, s, f_valid, f, e1, !e1, !e1);
            end
            step();
        end
    endtask

    task automatic test_stall();
        // Entered from G2 with req1 released so the grant stays on requester 2.
        req1 = 1'b0; req2 = 1'b1; x2 = 8'h5A; f_ready = 1'b1;
        #1;
        total++; if (gnt2 !== 1'b1 || rdy2 !== 1'b1) begin bad++; $display("FAIL stall_pre: got gnt2=%b rdy2=%b want 1 1", gnt2, rdy2); end
        step();
        f_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if ({gnt2, f_valid, rdy2, dut.beat_cnt} !== {3'b110, 8'd1}) begin
                bad++; $display("FAIL stall_cycle%0d: got g=%b v=%b r=%b cnt=%0d want 1 1 0 1", k, gnt2, f_valid, rdy2, dut.beat_cnt);
            end
            step();
        end
        f_ready = 1'b1;
        #1;
        total++; if (rdy2 !== 1'b1 || f !== 8'h5A) begin bad++; $display("FAIL stall_resume: got rdy2=%b f=%h want 1 5a", rdy2, f); end
        step();
        #1;
        total++; if (dut.beat_cnt !== 8'd2) begin bad++; $display("FAIL stall_cnt: got %0d want 2", dut.beat_cnt); end
    endtask

    task automatic test_drop();
        req1 = 1'b1; req2 = 1'b0;
        step();
        #1;
        total++; if (gnt1 !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL drop_to_g1: got gnt1=%b s=%b want 1 0", gnt1, s); end
        req1 = 1'b0; req2 = 1'b1;
        step();
        #1;
        total++; if (gnt2 !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL drop_to_g2: got gnt2=%b s=%b want 1 1", gnt2, s); end
        req2 = 1'b0;
        step();
        step();
        #1;
        total++; if ({gnt1, gnt2, s} !== 3'b001) begin bad++; $display("FAIL drop_idle: got %b%b%b want 001", gnt1, gnt2, s); end
    endtask

    task automatic test_reset_mid();
        req1 = 1'b0; req2 = 1'b1; last2 = 1'b0; f_ready = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++; if (f_valid !== 1'b1 || gnt2 !== 1'b1) begin bad++; $display("FAIL rmid_inflight: got v=%b g2=%b want 1 1", f_valid, gnt2); end
        step();
        rst_n = 1'b1; req1 = 1'b1; req2 = 1'b1;
        #1;
        total++; if ({gnt1, gnt2, s, f_valid} !== 4'b0000) begin bad++; $display("FAIL rmid_reset: got %b%b%b%b want 0000", gnt1, gnt2, s, f_valid); end
        total++; if (dut.beat_cnt !== 8'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", dut.beat_cnt); end
        step();
        #1;
        total++; if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin bad++; $display("FAIL rmid_tie: got %b%b want 10", gnt1, gnt2); end
    endtask

    task automatic test_last_at_max();
        int beats = 0;
        do_reset();
        req1 = 1'b1; req2 = 1'b0; last1 = 1'b0; f_ready = 1'b1;
        step();
        for (int b = 0; b < MH; b++) begin
            last1 = (b == MH - 1);
            #1;
            if (gnt1 && f_valid && f_ready) beats++;
            if (b == MH - 1) begin
                total++; if (dut.beat_cnt !== 8'(MH - 1)) begin bad++; $display("FAIL lmax_cnt: got %0d want %0d", dut.beat_cnt, MH - 1); end
            end
            step();
        end
        last1 = 1'b0;
        #1;
        total++; if (beats !== MH) begin bad++; $display("FAIL lmax_beats: got %0d want %0d", beats, MH); end
        total++; if (gnt1 !== 1'b1 || dut.beat_cnt !== 8'd0) begin bad++; $display("FAIL lmax_reenter: got g1=%b cnt=%0d want 1 0", gnt1, dut.beat_cnt); end
        step();
        #1;
        total++; if (dut.beat_cnt !== 8'd1) begin bad++; $display("FAIL lmax_next: got %0d want 1", dut.beat_cnt); end
    endtask

    task automatic test_random();
        logic [W+6:0] ev;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst_n   = ($urandom_range(63) != 0);
            req1    = ($urandom_range(3) != 0);
            req2    = ($urandom_range(3) != 0);
            last1   = ($urandom_range(4) == 0);
            last2   = ($urandom_range(4) == 0);
            f_ready = ($urandom_range(3) != 0);
            x1      = W'($urandom);
            x2      = W'($urandom);
            #1;
            ev = exp_vec();
            total++;
            if ({gnt1, gnt2, s, f_valid, f_last, rdy1, rdy2, f} !== ev) begin
                bad++; $display("FAIL rand_out%0d: got %h want %h", k, {gnt1, gnt2, s, f_valid, f_last, rdy1, rdy2, f}, ev);
            end
            total++;
            if (dut.beat_cnt !== 8'(m_cnt)) begin
                bad++; $display("FAIL rand_cnt%0d: got %0d want %0d", k, dut.beat_cnt, m_cnt);
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; last1 = 1'b0; last2 = 1'b0;
        f_ready = 1'b0; x1 = '0; x2 = '0;
        test_reset();
        test_single_burst();
        test_alternate();
        test_stall();
        test_drop();
        test_reset_mid();
        test_last_at_max();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
